// File: rtl/fifo_pkg.sv
// Shared helpers for the tagged multi-flux FIFO: width functions, default-sized
// pointer/count types and the {tag, data} token layout.
package fifo_pkg;

    function automatic int tag_width(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEF_FLUX       = 2;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_DATA_WIDTH = 18;

    typedef logic [ptr_width(DEF_DEPTH)-1:0] ptr_t;
    typedef logic [cnt_width(DEF_DEPTH)-1:0] cnt_t;

    typedef struct packed {
        logic [tag_width(DEF_FLUX)-1:0] tag;
        logic [DEF_DATA_WIDTH-1:0]      data;
    } token_t;

endpackage

// File: rtl/read_interface.sv
// Consumer-side port of an actor FIFO: one-hot read select, head word, per-flux empty.
interface read_interface #(
    parameter int WIDTH = 19,
    parameter int FLUX  = 2
);
    logic [FLUX-1:0]  read;
    logic [WIDTH-1:0] dout;
    logic [FLUX-1:0]  empty;

    modport fifo  (input  read, output dout, output empty);
    modport actor (output read, input  dout, input  empty);
endinterface

// File: rtl/write_interface.sv
// Producer-side port of an actor FIFO: tagged write strobe plus per-flux full.
interface write_interface #(
    parameter int WIDTH = 19,
    parameter int FLUX  = 2
);
    logic             write;
    logic [WIDTH-1:0] din;
    logic [FLUX-1:0]  full;

    modport fifo  (input  write, input  din, output full);
    modport actor (output write, output din, input  full);
endinterface

// File: rtl/flux_ring_ctrl.sv
// Pointer/occupancy bookkeeping for one flux ring; enables arrive pre-qualified.
module flux_ring_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = ptr_width(DEPTH),
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic          rd_en_i,
    output logic [PW-1:0] wptr_o,
    output logic [PW-1:0] rptr_o,
    output logic          empty_o,
    output logic          full_o
);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_comb begin
        wptr_d = wptr_q + PW'(wr_en_i);
        rptr_d = rptr_q + PW'(rd_en_i);
        cnt_d  = cnt_q + CW'(wr_en_i) - CW'(rd_en_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign wptr_o  = wptr_q;
    assign rptr_o  = rptr_q;
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/tagged_flux_fifo.sv
// Multi-flux FIFO channel: one ring per flux in shared storage, first-word-fall-through
// read selected by a one-hot strobe, sticky protocol error flag.
module tagged_flux_fifo
    import fifo_pkg::*;
#(
    parameter int FLUX       = 2,
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 18
) (
    input  logic         clk,
    input  logic         rst,
    write_interface.fifo write_port_in,
    read_interface.fifo  read_port_out,
    output logic         err
);

    localparam int TAG_WIDTH = tag_width(FLUX);
    localparam int PW        = ptr_width(DEPTH);

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } tok_t;

    tok_t                  wr_tok, rd_tok;
    logic                  tag_ok, multi_rd;
    logic [FLUX-1:0]       wr_dec, wr_en, rd_sel, rd_en, empty, full;
    logic [PW-1:0]         wptr [FLUX];
    logic [PW-1:0]         rptr [FLUX];
    logic [TAG_WIDTH-1:0]  rd_idx;
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [DATA_WIDTH-1:0] mem [FLUX*DEPTH];
    logic                  err_q, err_d;

    assign wr_tok = tok_t'(write_port_in.din);
    assign tag_ok = ({1'b0, wr_tok.tag} < (TAG_WIDTH+1)'(FLUX));

    // Lowest set bit wins when the consumer violates one-hot.
    assign rd_sel   = read_port_out.read & (~read_port_out.read + FLUX'(1));
    assign multi_rd = |(read_port_out.read & (read_port_out.read - FLUX'(1)));

    generate
        for (genvar gi = 0; gi < FLUX; gi++) begin : g_flux
            assign wr_dec[gi] = write_port_in.write & tag_ok & (wr_tok.tag == TAG_WIDTH'(gi));
            assign wr_en[gi]  = wr_dec[gi] & ~full[gi];
            assign rd_en[gi]  = rd_sel[gi] & ~empty[gi];

            flux_ring_ctrl #(.DEPTH(DEPTH)) u_ring (
                .clk_i   (clk),
                .rst_ni  (rst),
                .wr_en_i (wr_en[gi]),
                .rd_en_i (rd_en[gi]),
                .wptr_o  (wptr[gi]),
                .rptr_o  (rptr[gi]),
                .empty_o (empty[gi]),
                .full_o  (full[gi])
            );
        end
    endgenerate

    always_comb begin
        rd_idx = '0;
        rd_ptr = '0;
        wr_ptr = '0;
        for (int f = 0; f < FLUX; f++) begin
            if (rd_sel[f]) begin
                rd_idx = TAG_WIDTH'(f);
                rd_ptr = rptr[f];
            end
            if (wr_dec[f]) wr_ptr = wptr[f];
        end
    end

    always_ff @(posedge clk) begin
        if (|wr_en) mem[{wr_tok.tag, wr_ptr}] <= wr_tok.data;
    end

    always_comb begin
        rd_tok = '0;
        if (|rd_sel) begin
            rd_tok.tag  = rd_idx;
            rd_tok.data = mem[{rd_idx, rd_ptr}];
        end
    end

    assign err_d = err_q
                 | (write_port_in.write & (~tag_ok | (|(wr_dec & full))))
                 | (|(rd_sel & empty))
                 | multi_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign write_port_in.full   = full;
    assign read_port_out.empty  = empty;
    assign read_port_out.dout   = rd_tok;
    assign err                  = err_q;

endmodule

// File: tb/tb_tagged_flux_fifo.sv
// Directed bench for tagged_flux_fifo with a per-flux queue scoreboard.
module tb_tagged_flux_fifo;

    localparam int FLUX  = 2;
    localparam int DEPTH = 4;
    localparam int DW    = 18;
    localparam int TW    = 1;
    localparam int W     = DW + TW;

    logic clk = 1'b0;
    logic rst;
    logic err;

    write_interface #(.WIDTH(W), .FLUX(FLUX)) wif ();
    read_interface  #(.WIDTH(W), .FLUX(FLUX)) rif ();

    tagged_flux_fifo #(.FLUX(FLUX), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .write_port_in (wif),
        .read_port_out (rif),
        .err           (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic exp_err;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic int qsize(input int f);
        return (f == 0) ? q0.size() : q1.size();
    endfunction

    task automatic check_flags(input string name);
        logic [1:0] e_empty, e_full;
        e_empty = {q1.size() == 0, q0.size() == 0};
        e_full  = {q1.size() == DEPTH, q0.size() == DEPTH};
        check($sformatf("%s empty", name), 32'(rif.empty), 32'(e_empty));
        check($sformatf("%s full", name), 32'(wif.full), 32'(e_full));
    endtask

    // One clock cycle of stimulus; entered and left 1 time unit after a rising edge.
    task automatic cycle(input logic wr, input logic [TW-1:0] tag, input logic [DW-1:0] data,
                         input logic [1:0] rd, input string name);
        int sel;
        logic wr_ok, rd_ok;
        logic [W-1:0] e_dout;
        wif.write = wr;
        wif.din   = {tag, data};
        rif.read  = rd;
        #1;
        check_flags(name);
        sel = rd[0] ? 0 : (rd[1] ? 1 : -1);
        rd_ok = (sel >= 0) && (qsize(sel) > 0);
        if (sel < 0) begin
            check($sformatf("%s dout idle", name), 32'(rif.dout), 32'd0);
        end else if (rd_ok) begin
            e_dout = {TW'(sel), (sel == 0) ? q0[0] : q1[0]};
            check($sformatf("%s dout", name), 32'(rif.dout), 32'(e_dout));
        end
        wr_ok = wr && (qsize(int'(tag)) < DEPTH);
        if (rd == 2'b11 || (sel >= 0 && !rd_ok) || (wr && !wr_ok)) exp_err = 1'b1;
        if (rd_ok) begin
            if (sel == 0) void'(q0.pop_front());
            else          void'(q1.pop_front());
        end
        if (wr_ok) begin
            if (tag == 0) q0.push_back(data);
            else          q1.push_back(data);
        end
        @(posedge clk);
        #1;
        check($sformatf("%s err", name), 32'(err), 32'(exp_err));
        wif.write = 1'b0;
        rif.read  = 2'b00;
    endtask

    task automatic do_reset(input string name);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        exp_err = 1'b0;
        #1;
        check($sformatf("%s rst empty", name), 32'(rif.empty), 32'h3);
        check($sformatf("%s rst full", name), 32'(wif.full), 32'h0);
        check($sformatf("%s rst dout", name), 32'(rif.dout), 32'h0);
        check($sformatf("%s rst err", name), 32'(err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        wif.write = 1'b0;
        wif.din   = '0;
        rif.read  = 2'b00;
        exp_err   = 1'b0;
        #1;
        do_reset("init");
        cycle(1'b0, 1'b0, 18'h0, 2'b00, "idle");

        // Fill flux 0, overflow, drain.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, DW'(i), 2'b00, $sformatf("fill0_%0d", i));
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 18'h0, 2'b01, $sformatf("drain0_%0d", i));
        cycle(1'b0, 1'b0, 18'h0, 2'b00, "drained0");

        // Interleaved fluxes.
        do_reset("ilv");
        cycle(1'b1, 1'b0, 18'h0A0, 2'b00, "ilv_wA0");
        cycle(1'b1, 1'b1, 18'h0B0, 2'b00, "ilv_wB0");
        cycle(1'b1, 1'b0, 18'h0A1, 2'b00, "ilv_wA1");
        cycle(1'b1, 1'b1, 18'h0B1, 2'b00, "ilv_wB1");
        cycle(1'b0, 1'b0, 18'h0, 2'b01, "ilv_rA0");
        cycle(1'b0, 1'b0, 18'h0, 2'b10, "ilv_rB0");
        cycle(1'b0, 1'b0, 18'h0, 2'b01, "ilv_rA1");
        cycle(1'b0, 1'b0, 18'h0, 2'b10, "ilv_rB1");
        cycle(1'b0, 1'b0, 18'h0, 2'b00, "ilv_end");

        // Same-cycle write+read on a full flux 1.
        do_reset("full1");
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, DW'(18'h100 + i), 2'b00, $sformatf("full1_w%0d", i));
        cycle(1'b1, 1'b1, 18'h1FF, 2'b10, "full1_wr_rd");
        cycle(1'b0, 1'b0, 18'h0, 2'b00, "full1_after");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 18'h0, 2'b10, $sformatf("full1_r%0d", i));

        // Same-cycle write+read on an empty flux 1.
        do_reset("empty1");
        cycle(1'b1, 1'b1, 18'h2AB, 2'b10, "empty1_wr_rd");
        cycle(1'b0, 1'b0, 18'h0, 2'b10, "empty1_read");

        // Non-one-hot read: lowest bit served.
        do_reset("multi");
        cycle(1'b1, 1'b0, 18'h3C0, 2'b00, "multi_w0");
        cycle(1'b1, 1'b1, 18'h3C1, 2'b00, "multi_w1");
        cycle(1'b0, 1'b0, 18'h0, 2'b11, "multi_rd");
        cycle(1'b0, 1'b0, 18'h0, 2'b10, "multi_r1");

        // Steady-state streaming across pointer wrap.
        do_reset("stream");
        cycle(1'b1, 1'b0, 18'h10000, 2'b00, "stream_p0");
        cycle(1'b1, 1'b0, 18'h10001, 2'b00, "stream_p1");
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 1'b0, DW'(18'h10002 + i), 2'b01, $sformatf("stream_%0d", i));

        // Asynchronous reset with tokens queued.
        do_reset("arst");
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DW'(18'h20 + i), 2'b00, $sformatf("arst_w%0d", i));
        #3;
        rst = 1'b0;
        q0.delete();
        q1.delete();
        exp_err = 1'b0;
        #1;
        check("arst async empty", 32'(rif.empty), 32'h3);
        check("arst async full", 32'(wif.full), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b1, 1'b0, 18'h3FFFF, 2'b00, "arst_wnew");
        cycle(1'b0, 1'b0, 18'h0, 2'b01, "arst_rnew");
        cycle(1'b0, 1'b0, 18'h0, 2'b00, "arst_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
